tlb_ctrl: RTL and testbench

Sequencer that executes TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB on behalf of the EXE-stage CSR path. It is the initiator side of the TLB array's search-1, write, read and invalidate ports, with one transaction in flight at a time. It returns results to the CSR unit through a single-cycle done pulse. Fetch-side translation keeps search port 0 and is out of scope.

---
 rtl/tlb_pkg.sv | 128 ++++++++++++
 rtl/tlb_fill_ctr.sv | 21 ++
 rtl/tlb_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB controller definitions: instruction op encodings, ELO and packed
// entry field layout, and helpers to move between CSR and array formats.
package tlb_pkg;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    localparam int VPPN_W  = 19;
    localparam int ASID_W  = 10;
    localparam int PS_W    = 6;
    localparam int PPN_W   = 20;
    localparam int ELO_W   = 27;
    localparam int ENTRY_W = 89;

    localparam int ELO_V   = 0;
    localparam int ELO_D   = 1;
    localparam int ELO_MAT = 2;
    localparam int ELO_PLV = 4;
    localparam int ELO_G   = 6;
    localparam int ELO_PPN = 7;

    // Bit offsets inside the 89-bit array word, odd page in the low bits.
    localparam int E_PPN1 = 0;
    localparam int E_PLV1 = 20;
    localparam int E_MAT1 = 22;
    localparam int E_D1   = 24;
    localparam int E_V1   = 25;
    localparam int E_PPN0 = 26;
    localparam int E_PLV0 = 46;
    localparam int E_MAT0 = 48;
    localparam int E_D0   = 50;
    localparam int E_V0   = 51;
    localparam int E_E    = 52;
    localparam int E_PS   = 53;
    localparam int E_G    = 59;
    localparam int E_ASID = 60;
    localparam int E_VPPN = 70;

    typedef struct packed {
        logic             v;
        logic             d;
        logic [1:0]       mat;
        logic [1:0]       plv;
        logic [PPN_W-1:0] ppn;
    } tlb_page_t;

    typedef struct packed {
        logic [VPPN_W-1:0] vppn;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PS_W-1:0]   ps;
        logic              e;
        tlb_page_t         p0;
        tlb_page_t         p1;
    } tlb_entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input tlb_entry_t ent);
        logic [ENTRY_W-1:0] w;
        w = '0;
        w[E_VPPN +: VPPN_W] = ent.vppn;
        w[E_ASID +: ASID_W] = ent.asid;
        w[E_G]              = ent.g;
        w[E_PS +: PS_W]     = ent.ps;
        w[E_E]              = ent.e;
        w[E_V0]             = ent.p0.v;
        w[E_D0]             = ent.p0.d;
        w[E_MAT0 +: 2]      = ent.p0.mat;
        w[E_PLV0 +: 2]      = ent.p0.plv;
        w[E_PPN0 +: PPN_W]  = ent.p0.ppn;
        w[E_V1]             = ent.p1.v;
        w[E_D1]             = ent.p1.d;
        w[E_MAT1 +: 2]      = ent.p1.mat;
        w[E_PLV1 +: 2]      = ent.p1.plv;
        w[E_PPN1 +: PPN_W]  = ent.p1.ppn;
        return w;
    endfunction

    function automatic tlb_entry_t unpack_entry(input logic [ENTRY_W-1:0] w);
        tlb_entry_t ent;
        ent.vppn   = w[E_VPPN +: VPPN_W];
        ent.asid   = w[E_ASID +: ASID_W];
        ent.g      = w[E_G];
        ent.ps     = w[E_PS +: PS_W];
        ent.e      = w[E_E];
        ent.p0.v   = w[E_V0];
        ent.p0.d   = w[E_D0];
        ent.p0.mat = w[E_MAT0 +: 2];
        ent.p0.plv = w[E_PLV0 +: 2];
        ent.p0.ppn = w[E_PPN0 +: PPN_W];
        ent.p1.v   = w[E_V1];
        ent.p1.d   = w[E_D1];
        ent.p1.mat = w[E_MAT1 +: 2];
        ent.p1.plv = w[E_PLV1 +: 2];
        ent.p1.ppn = w[E_PPN1 +: PPN_W];
        return ent;
    endfunction

    function automatic tlb_page_t page_from_elo(input logic [ELO_W-1:0] elo);
        tlb_page_t p;
        p.v   = elo[ELO_V];
        p.d   = elo[ELO_D];
        p.mat = elo[ELO_MAT +: 2];
        p.plv = elo[ELO_PLV +: 2];
        p.ppn = elo[ELO_PPN +: PPN_W];
        return p;
    endfunction

    // The array keeps one global bit per entry; TLBRD reports it in both ELOs.
    function automatic logic [ELO_W-1:0] elo_from_page(input tlb_page_t p, input logic g);
        logic [ELO_W-1:0] elo;
        elo = '0;
        elo[ELO_V]          = p.v;
        elo[ELO_D]          = p.d;
        elo[ELO_MAT +: 2]   = p.mat;
        elo[ELO_PLV +: 2]   = p.plv;
        elo[ELO_G]          = g;
        elo[ELO_PPN +: PPN_W] = p.ppn;
        return elo;
    endfunction

endpackage

// File: rtl/tlb_fill_ctr.sv
// Free-running entry index used by TLBFILL as its pseudo-random victim choice.
module tlb_fill_ctr #(
    parameter int TLBNUM = 2,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (value == IDX_W'(TLBNUM - 1)) begin
            value <= '0;
        end else begin
            value <= value + IDX_W'(1);
        end
    end

endmodule

// File: rtl/tlb_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: drives the TLB array's
// search-1, read, write and invalidate ports and returns a one-cycle done pulse.
module tlb_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 2,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [4:0]         req_inv_op,
    input  logic [9:0]         req_inv_asid,
    input  logic [18:0]        req_inv_vpn,
    input  logic [9:0]         csr_asid,
    input  logic [18:0]        csr_ehi_vppn,
    input  logic [IDX_W-1:0]   csr_idx,
    input  logic [5:0]         csr_ps,
    input  logic               csr_ne,
    input  logic [26:0]        csr_elo0,
    input  logic [26:0]        csr_elo1,
    input  logic               csr_refill,
    output logic               tlb_s1_fetch,
    output logic [18:0]        tlb_s1_vppn,
    output logic               tlb_s1_odd_page,
    output logic [9:0]         tlb_s1_asid,
    input  logic               tlb_s1_found,
    input  logic [IDX_W-1:0]   tlb_s1_index,
    output logic               tlb_we,
    output logic [IDX_W-1:0]   tlb_w_index,
    output logic [ENTRY_W-1:0] tlb_w_entry,
    output logic [IDX_W-1:0]   tlb_r_index,
    input  logic [ENTRY_W-1:0] tlb_r_entry,
    output logic               tlb_inv_en,
    output logic [4:0]         tlb_inv_op,
    output logic [9:0]         tlb_inv_asid,
    output logic [18:0]        tlb_inv_vpn,
    output logic               done_valid,
    output logic [2:0]         done_op,
    output logic               res_found,
    output logic [IDX_W-1:0]   res_index,
    output logic               res_err,
    output logic               res_ne,
    output logic [5:0]         res_ps,
    output logic [18:0]        res_vppn,
    output logic [9:0]         res_asid,
    output logic [26:0]        res_elo0,
    output logic [26:0]        res_elo1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWAIT,
        S_RESP
    } state_e;

    state_e           state;
    state_e           state_next;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] fill_idx;
    logic             accept;
    logic             inv_op_ok;
    tlb_entry_t       wr_ent;
    tlb_entry_t       rd_ent;

    tlb_fill_ctr #(
        .TLBNUM (TLBNUM),
        .IDX_W  (IDX_W)
    ) u_fill_ctr (
        .clk   (clk),
        .reset (reset),
        .value (fill_idx)
    );

    assign accept          = (state == S_IDLE) && req_valid;
    assign inv_op_ok       = (req_inv_op <= INV_OP_MAX);
    assign rd_ent          = unpack_entry(tlb_r_entry);
    assign req_ready       = (state == S_IDLE);
    assign done_valid      = (state == S_RESP);
    assign done_op         = op_q;
    assign tlb_s1_odd_page = 1'b0;

    // An entry is live unless software marked it not-present; refill always installs.
    always_comb begin
        wr_ent      = '0;
        wr_ent.vppn = csr_ehi_vppn;
        wr_ent.asid = csr_asid;
        wr_ent.g    = csr_elo0[ELO_G] & csr_elo1[ELO_G];
        wr_ent.ps   = csr_ps;
        wr_ent.e    = csr_refill | ~csr_ne;
        wr_ent.p0   = page_from_elo(csr_elo0);
        wr_ent.p1   = page_from_elo(csr_elo1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Array port strobes and their data are only driven in the accept cycle.
    always_comb begin
        state_next   = state;
        tlb_s1_fetch = 1'b0;
        tlb_s1_vppn  = '0;
        tlb_s1_asid  = '0;
        tlb_we       = 1'b0;
        tlb_w_index  = '0;
        tlb_w_entry  = '0;
        tlb_r_index  = '0;
        tlb_inv_en   = 1'b0;
        tlb_inv_op   = '0;
        tlb_inv_asid = '0;
        tlb_inv_vpn  = '0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_RESP;
                    case (req_op)
                        OP_SRCH: begin
                            tlb_s1_fetch = 1'b1;
                            tlb_s1_vppn  = csr_ehi_vppn;
                            tlb_s1_asid  = csr_asid;
                            state_next   = S_SWAIT;
                        end
                        OP_RD: begin
                            tlb_r_index = csr_idx;
                        end
                        OP_WR, OP_FILL: begin
                            tlb_we      = 1'b1;
                            tlb_w_index = (req_op == OP_FILL) ? fill_idx : csr_idx;
                            tlb_w_entry = pack_entry(wr_ent);
                        end
                        OP_INV: begin
                            if (inv_op_ok) begin
                                tlb_inv_en   = 1'b1;
                                tlb_inv_op   = req_inv_op;
                                tlb_inv_asid = req_inv_asid;
                                tlb_inv_vpn  = req_inv_vpn;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_SWAIT: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Results are cleared on accept and then hold until the next instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            res_found <= 1'b0;
            res_index <= '0;
            res_err   <= 1'b0;
            res_ne    <= 1'b0;
            res_ps    <= '0;
            res_vppn  <= '0;
            res_asid  <= '0;
            res_elo0  <= '0;
            res_elo1  <= '0;
        end else if (accept) begin
            op_q      <= req_op;
            res_found <= 1'b0;
            res_index <= '0;
            res_err   <= (req_op == OP_INV) && !inv_op_ok;
            res_ne    <= 1'b0;
            res_ps    <= '0;
            res_vppn  <= '0;
            res_asid  <= '0;
            res_elo0  <= '0;
            res_elo1  <= '0;
            if (req_op == OP_RD) begin
                if (rd_ent.e) begin
                    res_ps   <= rd_ent.ps;
                    res_vppn <= rd_ent.vppn;
                    res_asid <= rd_ent.asid;
                    res_elo0 <= elo_from_page(rd_ent.p0, rd_ent.g);
                    res_elo1 <= elo_from_page(rd_ent.p1, rd_ent.g);
                end else begin
                    res_ne <= 1'b1;
                end
            end
        end else if (state == S_SWAIT) begin
            res_found <= tlb_s1_found;
            res_index <= tlb_s1_found ? tlb_s1_index : '0;
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: a small TLB array model answers the ports,
// and expected completions are queued at accept and checked on done_valid.
module tb_tlb_ctrl;

    localparam int TLBNUM = 2;
    localparam int IDX_W  = 1;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [4:0]       req_inv_op;
    logic [9:0]       req_inv_asid;
    logic [18:0]      req_inv_vpn;
    logic [9:0]       csr_asid;
    logic [18:0]      csr_ehi_vppn;
    logic [IDX_W-1:0] csr_idx;
    logic [5:0]       csr_ps;
    logic             csr_ne;
    logic [26:0]      csr_elo0;
    logic [26:0]      csr_elo1;
    logic             csr_refill;
    logic             tlb_s1_fetch;
    logic [18:0]      tlb_s1_vppn;
    logic             tlb_s1_odd_page;
    logic [9:0]       tlb_s1_asid;
    logic             tlb_s1_found;
    logic [IDX_W-1:0] tlb_s1_index;
    logic             tlb_we;
    logic [IDX_W-1:0] tlb_w_index;
    logic [88:0]      tlb_w_entry;
    logic [IDX_W-1:0] tlb_r_index;
    logic [88:0]      tlb_r_entry;
    logic             tlb_inv_en;
    logic [4:0]       tlb_inv_op;
    logic [9:0]       tlb_inv_asid;
    logic [18:0]      tlb_inv_vpn;
    logic             done_valid;
    logic [2:0]       done_op;
    logic             res_found;
    logic [IDX_W-1:0] res_index;
    logic             res_err;
    logic             res_ne;
    logic [5:0]       res_ps;
    logic [18:0]      res_vppn;
    logic [9:0]       res_asid;
    logic [26:0]      res_elo0;
    logic [26:0]      res_elo1;

    tlb_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vpn(req_inv_vpn),
        .csr_asid(csr_asid), .csr_ehi_vppn(csr_ehi_vppn), .csr_idx(csr_idx),
        .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .csr_refill(csr_refill),
        .tlb_s1_fetch(tlb_s1_fetch), .tlb_s1_vppn(tlb_s1_vppn),
        .tlb_s1_odd_page(tlb_s1_odd_page), .tlb_s1_asid(tlb_s1_asid),
        .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
        .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
        .tlb_inv_en(tlb_inv_en), .tlb_inv_op(tlb_inv_op),
        .tlb_inv_asid(tlb_inv_asid), .tlb_inv_vpn(tlb_inv_vpn),
        .done_valid(done_valid), .done_op(done_op),
        .res_found(res_found), .res_index(res_index), .res_err(res_err),
        .res_ne(res_ne), .res_ps(res_ps), .res_vppn(res_vppn), .res_asid(res_asid),
        .res_elo0(res_elo0), .res_elo1(res_elo1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]       op;
        int               lat;
        int               acc;
        bit               chk_srch;
        bit               chk_rd;
        bit               chk_inv;
        logic             found;
        logic [IDX_W-1:0] index;
        logic             err;
        logic             ne;
        logic [5:0]       ps;
        logic [18:0]      vppn;
        logic [9:0]       asid;
        logic [26:0]      elo0;
        logic [26:0]      elo1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // TLB array model: registered search hit, combinational read, write at edge.
    logic [88:0]      tlb_arr [TLBNUM];
    logic             s1_found_q;
    logic [IDX_W-1:0] s1_index_q;

    assign tlb_s1_found = s1_found_q;
    assign tlb_s1_index = s1_index_q;
    assign tlb_r_entry  = tlb_arr[tlb_r_index];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) tlb_arr[i] <= '0;
            s1_found_q <= 1'b0;
            s1_index_q <= '0;
        end else begin
            if (tlb_we) tlb_arr[tlb_w_index] <= tlb_w_entry;
            s1_found_q <= 1'b0;
            s1_index_q <= '0;
            if (tlb_s1_fetch) begin
                for (int i = 0; i < TLBNUM; i++) begin
                    if (tlb_arr[i][52] && tlb_arr[i][88:70] == tlb_s1_vppn &&
                        (tlb_arr[i][59] || tlb_arr[i][69:60] == tlb_s1_asid)) begin
                        s1_found_q <= 1'b1;
                        s1_index_q <= IDX_W'(i);
                    end
                end
            end
        end
    end

    function automatic logic [88:0] make_entry(input logic [18:0] vppn, input logic [9:0] asid,
                                               input logic g, input logic [5:0] ps, input logic e,
                                               input logic [26:0] lo0, input logic [26:0] lo1);
        return {vppn, asid, g, ps, e,
                lo0[0], lo0[1], lo0[3:2], lo0[5:4], lo0[26:7],
                lo1[0], lo1[1], lo1[3:2], lo1[5:4], lo1[26:7]};
    endfunction

    function automatic exp_t new_exp(input logic [2:0] op, input int lat);
        exp_t e;
        e.op = op;  e.lat = lat;  e.acc = 0;
        e.chk_srch = 1'b0;  e.chk_rd = 1'b0;  e.chk_inv = 1'b0;
        e.found = 1'b0;  e.index = '0;  e.err = 1'b0;  e.ne = 1'b0;
        e.ps = '0;  e.vppn = '0;  e.asid = '0;  e.elo0 = '0;  e.elo1 = '0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", 128'(req_ready), 128'(1));
        req_op    = op;
        req_valid = 1'b1;
        #1;
    endtask

    task automatic acceptStimulus(input exp_t e, input bit push);
        exp_t x;
        x     = e;
        x.acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) sb.push_back(x);
    endtask

    task automatic waitDone();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("done_timeout", 128'(sb.size()), 128'(0));
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && done_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 128'(1), 128'(0));
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_op", 128'(done_op), 128'(mon_e.op));
                checkOutput("latency", 128'(cyc - mon_e.acc + 1), 128'(mon_e.lat));
                if (mon_e.chk_srch) begin
                    checkOutput("res_found", 128'(res_found), 128'(mon_e.found));
                    checkOutput("res_index", 128'(res_index), 128'(mon_e.index));
                end
                if (mon_e.chk_rd) begin
                    checkOutput("res_ne",   128'(res_ne),   128'(mon_e.ne));
                    checkOutput("res_ps",   128'(res_ps),   128'(mon_e.ps));
                    checkOutput("res_vppn", 128'(res_vppn), 128'(mon_e.vppn));
                    checkOutput("res_asid", 128'(res_asid), 128'(mon_e.asid));
                    checkOutput("res_elo0", 128'(res_elo0), 128'(mon_e.elo0));
                    checkOutput("res_elo1", 128'(res_elo1), 128'(mon_e.elo1));
                end
                if (mon_e.chk_inv) checkOutput("res_err", 128'(res_err), 128'(mon_e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        logic [26:0] e1_lo0, e1_lo1, e0_lo0, e0_lo1;
        int dcount;
        int last_par;
        int exp_idx;

        req_valid = 1'b0;  req_op = '0;
        req_inv_op = '0;  req_inv_asid = '0;  req_inv_vpn = '0;
        csr_asid = '0;  csr_ehi_vppn = '0;  csr_idx = '0;  csr_ps = '0;
        csr_ne = 1'b0;  csr_elo0 = '0;  csr_elo1 = '0;  csr_refill = 1'b0;
        e1_lo0 = {20'hABCDE, 1'b1, 2'd3, 2'd1, 1'b1, 1'b1};
        e1_lo1 = {20'h12345, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1};
        e0_lo0 = {20'h11111, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0};
        e0_lo1 = {20'h22222, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 128'(req_ready), 128'(1));
        checkOutput("rst_done",  128'(done_valid), 128'(0));
        checkOutput("rst_op",    128'(done_op), 128'(0));
        checkOutput("rst_strb",  128'({tlb_we, tlb_s1_fetch, tlb_inv_en}), 128'(0));
        checkOutput("rst_went",  128'(tlb_w_entry), 128'(0));
        checkOutput("rst_res",   128'({res_found, res_err, res_ne, res_elo0}), 128'(0));
        reset   = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);

        // WR entry 1: refill forces e=1 despite ne=1; g is the AND of both ELO g bits
        csr_idx = 1'b1;  csr_ne = 1'b1;  csr_refill = 1'b1;  csr_ps = 6'd12;
        csr_ehi_vppn = 19'h00123;  csr_asid = 10'd5;  csr_elo0 = e1_lo0;  csr_elo1 = e1_lo1;
        applyStimulus(OP_WR);
        checkOutput("wr_we",     128'(tlb_we), 128'(1));
        checkOutput("wr_index",  128'(tlb_w_index), 128'(1));
        checkOutput("wr_entry",  128'(tlb_w_entry),
                    128'(make_entry(19'h00123, 10'd5, 1'b0, 6'd12, 1'b1, e1_lo0, e1_lo1)));
        checkOutput("wr_others", 128'({tlb_s1_fetch, tlb_inv_en}), 128'(0));
        acceptStimulus(new_exp(OP_WR, 2), 1'b1);
        checkOutput("wr_we_once", 128'(tlb_we), 128'(0));
        checkOutput("busy_ready", 128'(req_ready), 128'(0));
        waitDone();

        // WR entry 0 not-present without refill: e=0
        csr_idx = 1'b0;  csr_ne = 1'b1;  csr_refill = 1'b0;  csr_ps = 6'd21;
        csr_ehi_vppn = 19'h7ABCD;  csr_asid = 10'h2AA;  csr_elo0 = e0_lo0;  csr_elo1 = e0_lo1;
        applyStimulus(OP_WR);
        checkOutput("wr0_entry", 128'(tlb_w_entry),
                    128'(make_entry(19'h7ABCD, 10'h2AA, 1'b1, 6'd21, 1'b0, e0_lo0, e0_lo1)));
        acceptStimulus(new_exp(OP_WR, 2), 1'b1);
        waitDone();

        // RD of an absent entry reports ne and zeros
        csr_idx = 1'b0;
        applyStimulus(OP_RD);
        checkOutput("rd0_rindex", 128'(tlb_r_index), 128'(0));
        checkOutput("rd0_strb",   128'({tlb_we, tlb_s1_fetch, tlb_inv_en}), 128'(0));
        e = new_exp(OP_RD, 2);
        e.chk_rd = 1'b1;  e.ne = 1'b1;
        acceptStimulus(e, 1'b1);
        waitDone();

        // RD of entry 1 returns its fields with g copied into both ELOs
        csr_idx = 1'b1;
        applyStimulus(OP_RD);
        checkOutput("rd1_rindex", 128'(tlb_r_index), 128'(1));
        e = new_exp(OP_RD, 2);
        e.chk_rd = 1'b1;  e.ne = 1'b0;  e.ps = 6'd12;  e.vppn = 19'h00123;  e.asid = 10'd5;
        e.elo0 = {e1_lo0[26:7], 1'b0, e1_lo0[5:0]};
        e.elo1 = {e1_lo1[26:7], 1'b0, e1_lo1[5:0]};
        acceptStimulus(e, 1'b1);
        waitDone();

        // SRCH hit on entry 1; a request held during SWAIT must be ignored
        csr_ehi_vppn = 19'h00123;  csr_asid = 10'd5;
        applyStimulus(OP_SRCH);
        checkOutput("srch_fetch", 128'(tlb_s1_fetch), 128'(1));
        checkOutput("srch_key",   128'({tlb_s1_vppn, tlb_s1_asid, tlb_s1_odd_page}),
                    128'({19'h00123, 10'd5, 1'b0}));
        checkOutput("srch_excl",  128'({tlb_we, tlb_inv_en}), 128'(0));
        e = new_exp(OP_SRCH, 3);
        e.chk_srch = 1'b1;  e.found = 1'b1;  e.index = 1'b1;
        acceptStimulus(e, 1'b1);
        req_op = OP_WR;  req_valid = 1'b1;
        #1;
        checkOutput("busy_ignore", 128'({tlb_we, tlb_s1_fetch, req_ready}), 128'(0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waitDone();

        // SRCH miss: non-global entry with a different ASID
        csr_asid = 10'd6;
        applyStimulus(OP_SRCH);
        e = new_exp(OP_SRCH, 3);
        e.chk_srch = 1'b1;  e.found = 1'b0;  e.index = 1'b0;
        acceptStimulus(e, 1'b1);
        waitDone();

        // INV with an undefined op: no strobe, error flagged
        req_inv_op = 5'd7;  req_inv_asid = 10'd9;  req_inv_vpn = 19'h00042;
        applyStimulus(OP_INV);
        checkOutput("inv7_strb", 128'({tlb_inv_en, tlb_we, tlb_s1_fetch}), 128'(0));
        e = new_exp(OP_INV, 2);
        e.chk_inv = 1'b1;  e.err = 1'b1;
        acceptStimulus(e, 1'b1);
        waitDone();

        req_inv_op = 5'd4;  req_inv_asid = 10'd3;  req_inv_vpn = 19'h00055;
        applyStimulus(OP_INV);
        checkOutput("inv4_port", 128'({tlb_inv_en, tlb_inv_op, tlb_inv_asid, tlb_inv_vpn}),
                    128'({1'b1, 5'd4, 10'd3, 19'h00055}));
        e = new_exp(OP_INV, 2);
        e.chk_inv = 1'b1;  e.err = 1'b0;
        acceptStimulus(e, 1'b1);
        checkOutput("inv4_once", 128'(tlb_inv_en), 128'(0));
        waitDone();

        // Reset in SWAIT drops the search with no completion
        applyStimulus(OP_SRCH);
        acceptStimulus(new_exp(OP_SRCH, 3), 1'b0);
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        rel_cyc = cyc;
        dcount  = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_valid) dcount++;
        end
        checkOutput("rst_no_done", 128'(dcount), 128'(0));
        checkOutput("rst_ready2",  128'(req_ready), 128'(1));

        // FILL at alternating cycle parities: index tracks the wrapping counter
        csr_ne = 1'b0;  csr_refill = 1'b0;  csr_idx = 1'b0;
        last_par = -1;
        for (int k = 0; k < 3; k++) begin
            if (((cyc - rel_cyc) % TLBNUM) == last_par) @(negedge clk);
            exp_idx = (cyc - rel_cyc) % TLBNUM;
            applyStimulus(OP_FILL);
            checkOutput("fill_index", 128'(tlb_w_index), 128'(exp_idx));
            checkOutput("fill_e",     128'(tlb_w_entry[52]), 128'(1));
            last_par = exp_idx;
            acceptStimulus(new_exp(OP_FILL, 2), 1'b1);
            waitDone();
        end

        checkOutput("sb_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
